// File: rtl/imem_loader.sv
// Boot-time instruction RAM writer: frames A5, N, then 4*N little-endian bytes into word writes at ADDR_BASE.
// Ports: clk/rst_n; RxData/RxValid/RxReady byte stream in; MemWrite/MemAddress/MemWriteData RAM write port;
//        CpuHold (CPU reset while loading or after a failed load), LoadDone pulse, LoadError sticky timeout flag.
module imem_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    // Must be word-aligned; the low two address bits are never touched by the index.
    parameter logic [31:0] ADDR_BASE      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  RxData,
    input  logic        RxValid,
    output logic        RxReady,
    output logic        MemWrite,
    output logic [31:0] MemAddress,
    output logic [31:0] MemWriteData,
    output logic        CpuHold,
    output logic        LoadDone,
    output logic        LoadError
);

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // The counter never needs to hold more than TIMEOUT_CYCLES-1.
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_DATA,
        S_WRITE,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [8:0]    remaining_q, remaining_d;
    logic [7:0]    index_q, index_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [31:0]   word_q, word_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic          rx_ready_d;
    logic          mem_write_d;
    logic [31:0]   mem_address_d;
    logic [31:0]   mem_write_data_d;
    logic          cpu_hold_d;
    logic          load_done_d;
    logic          load_error_d;

    logic          accept;
    logic [31:0]   word_next;

    assign accept = RxValid && RxReady;

    // Incoming byte merged into the partially assembled word.
    always_comb begin
        word_next = word_q;
        word_next[{byte_idx_q, 3'b000} +: 8] = RxData;
    end

    always_comb begin
        state_d          = state_q;
        remaining_d      = remaining_q;
        index_d          = index_q;
        byte_idx_d       = byte_idx_q;
        word_d           = word_q;
        tmo_d            = tmo_q;
        rx_ready_d       = RxReady;
        mem_write_d      = 1'b0;
        mem_address_d    = MemAddress;
        mem_write_data_d = MemWriteData;
        cpu_hold_d       = CpuHold;
        load_done_d      = 1'b0;
        load_error_d     = LoadError;

        case (state_q)
            S_IDLE: begin
                // Anything other than the sync byte is silently dropped.
                if (accept && (RxData == SYNC_BYTE)) begin
                    state_d      = S_HEADER;
                    cpu_hold_d   = 1'b1;
                    load_error_d = 1'b0;
                    tmo_d        = '0;
                end
            end

            S_HEADER: begin
                if (accept) begin
                    // A count of zero stands for the full 256-word image.
                    remaining_d = (RxData == 8'd0) ? 9'd256 : {1'b0, RxData};
                    index_d     = '0;
                    byte_idx_d  = '0;
                    tmo_d       = '0;
                    state_d     = S_DATA;
                end else if (tmo_q == TMO_LAST) begin
                    state_d      = S_IDLE;
                    load_error_d = 1'b1;
                    tmo_d        = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            S_DATA: begin
                if (accept) begin
                    // A sync byte here is payload, not a restart.
                    word_d     = word_next;
                    byte_idx_d = byte_idx_q + 2'd1;
                    tmo_d      = '0;
                    if (byte_idx_q == 2'd3) begin
                        state_d          = S_WRITE;
                        rx_ready_d       = 1'b0;
                        mem_write_d      = 1'b1;
                        mem_address_d    = ADDR_BASE + {22'd0, index_q, 2'b00};
                        mem_write_data_d = word_next;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    // Partial word is abandoned; CpuHold stays set.
                    state_d      = S_IDLE;
                    load_error_d = 1'b1;
                    tmo_d        = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            S_WRITE: begin
                index_d     = index_q + 8'd1;
                remaining_d = remaining_q - 9'd1;
                if (remaining_q == 9'd1) begin
                    state_d     = S_DONE;
                    load_done_d = 1'b1;
                end else begin
                    state_d    = S_DATA;
                    rx_ready_d = 1'b1;
                    byte_idx_d = '0;
                    tmo_d      = '0;
                end
            end

            S_DONE: begin
                state_d    = S_IDLE;
                cpu_hold_d = 1'b0;
                rx_ready_d = 1'b1;
            end

            default: begin
                state_d    = S_IDLE;
                rx_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            remaining_q  <= '0;
            index_q      <= '0;
            byte_idx_q   <= '0;
            word_q       <= '0;
            tmo_q        <= '0;
            RxReady      <= 1'b1;
            MemWrite     <= 1'b0;
            MemAddress   <= '0;
            MemWriteData <= '0;
            CpuHold      <= 1'b0;
            LoadDone     <= 1'b0;
            LoadError    <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            index_q      <= index_d;
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
            tmo_q        <= tmo_d;
            RxReady      <= rx_ready_d;
            MemWrite     <= mem_write_d;
            MemAddress   <= mem_address_d;
            MemWriteData <= mem_write_data_d;
            CpuHold      <= cpu_hold_d;
            LoadDone     <= load_done_d;
            LoadError    <= load_error_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  RxData = 8'h00;
    logic        RxValid = 1'b0;
    logic        RxReady;
    logic        MemWrite;
    logic [31:0] MemAddress;
    logic [31:0] MemWriteData;
    logic        CpuHold;
    logic        LoadDone;
    logic        LoadError;

    imem_loader #(
        .TIMEOUT_CYCLES(16),
        .ADDR_BASE     (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RxData      (RxData),
        .RxValid     (RxValid),
        .RxReady     (RxReady),
        .MemWrite    (MemWrite),
        .MemAddress  (MemAddress),
        .MemWriteData(MemWriteData),
        .CpuHold     (CpuHold),
        .LoadDone    (LoadDone),
        .LoadError   (LoadError)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    wr_t   exp_q[$];
    int    wr_cyc[$];
    int    wr_total = 0;
    int    done_cnt = 0;
    logic [31:0] last_addr = '0;
    bit    prev_done = 0;
    bit    chk_rdy = 0;
    wr_t   e;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (MemWrite) begin
                wr_cyc.push_back(cyc);
                wr_total++;
                last_addr = MemAddress;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL extra_write: got addr=%h data=%h, expected no write", MemAddress, MemWriteData);
                end else begin
                    e = exp_q.pop_front();
                    if (MemAddress !== e.a || MemWriteData !== e.d) begin
                        bad++;
                        $display("FAIL write: got addr=%h data=%h, expected addr=%h data=%h",
                                 MemAddress, MemWriteData, e.a, e.d);
                    end
                end
            end
            if (prev_done) begin
                total++;
                if (CpuHold !== 1'b0 || LoadDone !== 1'b0) begin
                    bad++;
                    $display("FAIL after_done: got hold=%b done=%b, expected hold=0 done=0", CpuHold, LoadDone);
                end
            end
            if (LoadDone) begin
                done_cnt++;
                total++;
                if (CpuHold !== 1'b1) begin
                    bad++;
                    $display("FAIL hold_at_done: got %b, expected 1", CpuHold);
                end
            end
            prev_done = LoadDone;
            if (chk_rdy) begin
                total++;
                if (RxReady !== !(MemWrite || LoadDone)) begin
                    bad++;
                    $display("FAIL rx_ready: got %b with write=%b done=%b", RxReady, MemWrite, LoadDone);
                end
            end
        end else begin
            prev_done = 0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        int w = 0;
        RxData  = b;
        RxValid = 1'b1;
        while (!RxReady && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (!RxReady) begin
            total++;
            bad++;
            $display("FAIL ready_wait: RxReady got 0 for 20 cycles, expected 1");
        end
        @(posedge clk);
        #1;
        RxValid = 1'b0;
    endtask

    task automatic send_frame(input int n);
        logic [7:0]  nb;
        logic [31:0] w;
        nb = 8'(n);
        send_byte(8'hA5);
        send_byte(nb);
        for (int i = 0; i < n; i++) begin
            w = $urandom();
            exp_q.push_back({32'(4 * i), w});
            send_byte(w[7:0]);
            send_byte(w[15:8]);
            send_byte(w[23:16]);
            send_byte(w[31:24]);
        end
    endtask

    task automatic wait_done(input int target);
        int w = 0;
        while (done_cnt < target && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        total++;
        if (done_cnt < target) begin
            bad++;
            $display("FAIL load_done: got %0d pulses, expected %0d", done_cnt, target);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({RxReady, MemWrite, CpuHold, LoadDone, LoadError} !== 5'b10000) begin
            bad++;
            $display("FAIL reset_ctrl: got %b, expected 10000", {RxReady, MemWrite, CpuHold, LoadDone, LoadError});
        end
        total++;
        if (MemAddress !== 32'h0 || MemWriteData !== 32'h0) begin
            bad++;
            $display("FAIL reset_mem: got addr=%h data=%h, expected 0 0", MemAddress, MemWriteData);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int d0 = done_cnt;
        total++;
        if (CpuHold !== 1'b0) begin bad++; $display("FAIL basic_hold_pre: got %b, expected 0", CpuHold); end
        send_byte(8'hA5);
        total++;
        if (CpuHold !== 1'b1) begin bad++; $display("FAIL basic_hold_sync: got %b, expected 1", CpuHold); end
        exp_q.push_back({32'h0, 32'h0151_2000});
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h20);
        send_byte(8'h51);
        send_byte(8'h01);
        wait_done(d0 + 1);
        total++;
        if (exp_q.size() != 0 || done_cnt != d0 + 1) begin
            bad++;
            $display("FAIL basic_count: got pending=%0d done=%0d, expected 0 %0d", exp_q.size(), done_cnt, d0 + 1);
        end
    endtask

    task automatic test_back_to_back();
        int d0 = done_cnt;
        wr_cyc.delete();
        chk_rdy = 1;
        send_frame(3);
        wait_done(d0 + 1);
        chk_rdy = 0;
        total++;
        if (wr_cyc.size() != 3) begin
            bad++;
            $display("FAIL b2b_writes: got %0d, expected 3", wr_cyc.size());
        end else begin
            total++;
            if (wr_cyc[1] - wr_cyc[0] != 5 || wr_cyc[2] - wr_cyc[1] != 5) begin
                bad++;
                $display("FAIL b2b_spacing: got %0d %0d, expected 5 5", wr_cyc[1] - wr_cyc[0], wr_cyc[2] - wr_cyc[1]);
            end
        end
    endtask

    task automatic test_max_frame();
        int d0 = done_cnt;
        int w0 = wr_total;
        send_frame(256);
        wait_done(d0 + 1);
        total++;
        if (wr_total - w0 != 256 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL max_count: got %0d writes pending=%0d, expected 256 0", wr_total - w0, exp_q.size());
        end
        total++;
        if (last_addr !== 32'h3FC) begin
            bad++;
            $display("FAIL max_last_addr: got %h, expected 000003fc", last_addr);
        end
    endtask

    task automatic test_reset_midframe();
        int w0 = wr_total;
        int d0 = done_cnt;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        RxData  = 8'h33;
        RxValid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({RxReady, MemWrite, CpuHold, LoadDone, LoadError} !== 5'b10000) begin
            bad++;
            $display("FAIL midrst_ctrl: got %b, expected 10000", {RxReady, MemWrite, CpuHold, LoadDone, LoadError});
        end
        total++;
        if (MemAddress !== 32'h0 || MemWriteData !== 32'h0) begin
            bad++;
            $display("FAIL midrst_mem: got addr=%h data=%h, expected 0 0", MemAddress, MemWriteData);
        end
        RxValid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        total++;
        if (wr_total != w0) begin
            bad++;
            $display("FAIL midrst_partial: got %0d writes, expected %0d", wr_total - w0, 0);
        end
        send_frame(1);
        wait_done(d0 + 1);
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL midrst_reload: got pending=%0d, expected 0", exp_q.size()); end
    endtask

    task automatic test_garbage();
        int d0 = done_cnt;
        logic [7:0] g[3] = '{8'h00, 8'hFF, 8'h13};
        for (int i = 0; i < 3; i++) begin
            send_byte(g[i]);
            total++;
            if (CpuHold !== 1'b0) begin bad++; $display("FAIL garbage_hold: got %b, expected 0", CpuHold); end
        end
        send_frame(1);
        wait_done(d0 + 1);
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL garbage_write: got pending=%0d, expected 0", exp_q.size()); end
    endtask

    task automatic test_timeout();
        int d0 = done_cnt;
        int w0 = wr_total;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h77);
        send_byte(8'h88);
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (LoadError !== (i == 16) || CpuHold !== 1'b1) begin
                bad++;
                $display("FAIL timeout_cycle%0d: got err=%b hold=%b, expected err=%b hold=1", i, LoadError, CpuHold, i == 16);
            end
        end
        total++;
        if (RxReady !== 1'b1 || wr_total != w0) begin
            bad++;
            $display("FAIL timeout_idle: got ready=%b writes=%0d, expected 1 0", RxReady, wr_total - w0);
        end
        send_byte(8'h00);
        total++;
        if (LoadError !== 1'b1 || CpuHold !== 1'b1) begin
            bad++;
            $display("FAIL timeout_sticky: got err=%b hold=%b, expected 1 1", LoadError, CpuHold);
        end
        exp_q.push_back({32'h0, 32'hA5C3_0F01});
        send_byte(8'hA5);
        total++;
        if (LoadError !== 1'b0 || CpuHold !== 1'b1) begin
            bad++;
            $display("FAIL timeout_clear: got err=%b hold=%b, expected 0 1", LoadError, CpuHold);
        end
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h0F);
        send_byte(8'hC3);
        send_byte(8'hA5);
        wait_done(d0 + 1);
        total++;
        if (CpuHold !== 1'b0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL timeout_recover: got hold=%b pending=%0d, expected 0 0", CpuHold, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_max_frame();
        test_reset_midframe();
        test_garbage();
        test_timeout();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL final_pending: got %0d, expected 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the CPU instruction memory: accepts a framed byte stream from the UART receiver, assembles little-endian 32-bit instruction words and issues one write per word into instruction RAM starting at a fixed base address. It is the write-side counterpart of the fetch-side instruction memory read. It also holds the CPU in reset while an image is loading, and keeps it held after a failed load.

## Interface
- TIMEOUT_CYCLES, 1000000: inter-byte timeout in clk cycles while a frame is open.
- ADDR_BASE, 32'h00000000: byte address written by word 0; must be word-aligned.

- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- RxData  input  8  received byte.
- RxValid  input  1  RxData valid.
- RxReady  output  1  loader can accept a byte.
- MemWrite  output  1  one-cycle write strobe to instruction RAM.
- MemAddress  output  32  byte address of the write; always word-aligned.
- MemWriteData  output  32  assembled instruction word.
- CpuHold  output  1  high keeps the CPU in reset.
- LoadDone  output  1  one-cycle pulse after the last word is written.
- LoadError  output  1  sticky; set on timeout.

## Operation
- Byte accepted on a rising edge with RxValid && RxReady.
- Frame format:
  - sync byte 8'hA5;
  - count byte N, where N=0 means 256 words;
  - 4*N data bytes, least-significant byte of each word first.
- States:
  - IDLE:
    - RxReady=1.
    - Accepted 8'hA5 -> HEADER, sets CpuHold=1 and clears LoadError.
    - Any other byte is discarded, no state change.
  - HEADER:
    - RxReady=1.
    - Accepted byte loads a 9-bit remaining count (0 loads 256), clears the word index and byte index -> DATA.
  - DATA:
    - RxReady=1.
    - The k-th accepted byte (k=0..3) is stored in MemWriteData[8k+7:8k].
    - The 4th byte -> WRITE.
  - WRITE:
    - Exactly one cycle; RxReady=0.
    - MemWrite=1, MemAddress=ADDR_BASE + 4*index (32-bit, wraps modulo 2^32).
    - index++, remaining--.
    - remaining reaching 0 -> DONE, otherwise -> DATA with byte index 0.
  - DONE:
    - Exactly one cycle; RxReady=0.
    - LoadDone=1; CpuHold clears at the end of this cycle -> IDLE.
- Timeout:
  - In HEADER and DATA, a counter clears on every accepted byte and on state entry, and increments otherwise.
  - Reaching TIMEOUT_CYCLES-1 -> IDLE, LoadError=1, CpuHold stays 1.
  - Partial word is dropped; no MemWrite.
  - Counter is idle in IDLE, WRITE and DONE.
- A sync byte received mid-frame is treated as data, not a restart.
- CpuHold stays 1 after an error until a later frame reaches DONE.
- Maximum frame writes words 0..255, filling a 1 KiB (256-word) RAM.

## Timing
- All outputs registered.
- Reset values (asynchronous, immediate on rst_n low):
  - state=IDLE, RxReady=1, MemWrite=0, MemAddress=0, MemWriteData=0;
  - CpuHold=0, LoadDone=0, LoadError=0, all counters 0.
- Reset mid-frame: any in-flight write strobe drops at once; no partial word is written after release.
- 4th data byte accepted on edge t: MemWrite is high in cycle t..t+1 and RxReady is low in that cycle. The next byte can be accepted on edge t+2.
- Last write in cycle c: LoadDone is high in cycle c+1 and CpuHold is low from cycle c+2.
- Sustained throughput: one word per 5 cycles with RxValid held high.
- MemAddress and MemWriteData hold their values outside WRITE; RAM samples them only when MemWrite=1.

## Test plan
- Reset then send A5, 01, 00, 20, 51, 01:
  - one MemWrite, MemAddress=0, MemWriteData=32'h01512000;
  - LoadDone pulses once; CpuHold 1 from sync acceptance to the cycle after LoadDone.
- Send A5, 03, then 12 bytes with RxValid held high:
  - writes at addresses 0, 4, 8, each exactly 5 cycles apart;
  - RxReady low exactly in WRITE and DONE cycles.
- Send A5, 00, then 1024 bytes: 256 writes, last at MemAddress=32'h3FC with correct data; no extra write.
- Send 00, FF, 13, then A5, 01 and 4 bytes:
  - the leading garbage bytes are ignored and CpuHold stays 0 until A5;
  - then one write.
- TIMEOUT_CYCLES=16: send A5, 01, 2 bytes, then idle:
  - LoadError=1 and state IDLE 16 cycles after the last accept;
  - no MemWrite; CpuHold stays 1;
  - a following good frame clears LoadError on its sync byte and drops CpuHold after LoadDone.
- Assert rst_n low during the 3rd data byte of a frame: all outputs take reset values immediately, and after release a full new frame loads correctly.
